// File: rtl/sram_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_if
// Purpose  : CPU/DMA requester ports and async SRAM pins for the arbiter.
// Revision : 1.0
// ============================================================================
interface sram_arb_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [18:0] cpu_a;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        cpu_ack;

    logic        dma_req;
    logic        dma_we;
    logic [18:0] dma_a;
    logic [7:0]  dma_di;
    logic [7:0]  dma_do;
    logic        dma_ack;

    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    // Requesters plus the SRAM data return path.
    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_di,
        output dma_req, dma_we, dma_a, dma_di,
        output sram_dq_i,
        input  cpu_do, cpu_ack, dma_do, dma_ack,
        input  sram_addr, sram_dq_o, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    // The arbiter itself.
    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_di,
        input  dma_req, dma_we, dma_a, dma_di,
        input  sram_dq_i,
        output cpu_do, cpu_ack, dma_do, dma_ack,
        output sram_addr, sram_dq_o, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface
`default_nettype wire

// File: rtl/sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb
// Purpose  : Round-robin CPU/DMA arbiter driving an 8-bit view of a 16-bit SRAM.
// Revision : 1.0
// ============================================================================
module sram_arb #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    sram_arb_if.slave  bus
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [3:0] c_last_wait = 4'(WAIT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_grant_dma;
    logic        r_last_dma;
    logic        r_we;
    logic [18:0] r_addr;
    logic [7:0]  r_di;
    logic [7:0]  r_cpu_do;
    logic [7:0]  r_dma_do;

    logic        w_pick_dma;
    logic        w_active;
    logic [7:0]  w_rd_byte;

    // DMA wins only if it is alone, or if the CPU had the previous grant.
    assign w_pick_dma = bus.dma_req && (!bus.cpu_req || !r_last_dma);
    assign w_rd_byte  = r_addr[0] ? bus.sram_dq_i[15:8] : bus.sram_dq_i[7:0];
    assign w_active   = (r_state != c_st_idle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_wait_cnt  <= 4'd0;
            r_grant_dma <= 1'b0;
            r_last_dma  <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= 19'd0;
            r_di        <= 8'd0;
            r_cpu_do    <= 8'd0;
            r_dma_do    <= 8'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        r_state     <= c_st_setup;
                        r_grant_dma <= w_pick_dma;
                        r_last_dma  <= w_pick_dma;
                        r_we        <= w_pick_dma ? bus.dma_we : bus.cpu_we;
                        r_addr      <= w_pick_dma ? bus.dma_a  : bus.cpu_a;
                        r_di        <= w_pick_dma ? bus.dma_di : bus.cpu_di;
                    end
                end
                c_st_setup: begin
                    r_state    <= c_st_access;
                    r_wait_cnt <= 4'd0;
                end
                c_st_access: begin
                    if (r_wait_cnt == c_last_wait) begin
                        r_state <= c_st_done;
                        if (!r_we) begin
                            if (r_grant_dma) r_dma_do <= w_rd_byte;
                            else             r_cpu_do <= w_rd_byte;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Strobes decode straight from registered state so reset clears them at once.
    assign bus.sram_addr  = r_addr[18:1];
    assign bus.sram_dq_o  = {r_di, r_di};
    assign bus.sram_dq_oe = r_we && w_active;
    assign bus.sram_ce_n  = !w_active;
    assign bus.sram_oe_n  = !(!r_we && (r_state == c_st_setup || r_state == c_st_access));
    assign bus.sram_we_n  = !(r_we && (r_state == c_st_access));
    assign bus.sram_lb_n  = !w_active || r_addr[0];
    assign bus.sram_ub_n  = !w_active || !r_addr[0];

    assign bus.cpu_ack    = (r_state == c_st_done) && !r_grant_dma;
    assign bus.dma_ack    = (r_state == c_st_done) && r_grant_dma;
    assign bus.cpu_do     = r_cpu_do;
    assign bus.dma_do     = r_dma_do;

endmodule
`default_nettype wire

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of ACCESS-state cycles per transfer; legal range 1..15.
REQ-002 clk  input  1  master clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req / cpu_we  input  1 / 1  CPU port transfer request / write (1) or read (0).
REQ-005 cpu_a / cpu_di  input  19 / 8  CPU byte address / write data.
REQ-006 cpu_do / cpu_ack  output  8 / 1  CPU read data / one-cycle completion pulse.
REQ-007 dma_req, dma_we, dma_a, dma_di, dma_do, dma_ack  same directions and widths as the CPU port; secondary requester (card loader / video fetch).
REQ-008 sram_addr  output  18  16-bit-word address to SRAM.
REQ-009 sram_dq_o / sram_dq_oe  output  16 / 1  write data / data-bus drive enable (top level tristates the bus).
REQ-010 sram_dq_i  input  16  SRAM read data.
REQ-011 sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  SRAM strobes, active-low.

Function
REQ-012 FSM states SHALL be IDLE, SETUP, ACCESS, DONE; IDLE->SETUP when any req=1; SETUP->ACCESS; ACCESS held WAIT_CYCLES cycles then ->DONE; DONE->IDLE.
REQ-013 Arbitration in IDLE SHALL be round-robin: with both reqs high, the port not granted last wins; with one req high, that port wins; last-grant register resets to DMA, so the CPU wins the first contention.
REQ-014 On the grant edge the arbiter SHALL latch port id, we, a[18:0] and di; latched values stay fixed until DONE regardless of requester inputs.
REQ-015 sram_addr SHALL equal latched a[18:1] from SETUP through DONE.
REQ-016 Byte lanes: a[0]=0 -> sram_lb_n=0, sram_ub_n=1; a[0]=1 -> sram_lb_n=1, sram_ub_n=0; both 1 in IDLE.
REQ-017 sram_ce_n SHALL be 0 in SETUP, ACCESS and DONE, and 1 in IDLE.
REQ-018 Read: sram_oe_n=0 in SETUP and ACCESS; 1 in DONE and IDLE; sram_we_n stays 1.
REQ-019 Write: sram_dq_o={di,di}; sram_dq_oe=1 in SETUP, ACCESS and DONE; sram_we_n=0 only in ACCESS; sram_oe_n stays 1.
REQ-020 Read data SHALL be captured on the final ACCESS edge: a[0]=0 -> dq_i[7:0], else dq_i[15:8]; captured into the granted port's do register only; do holds until that port's next read.
REQ-021 The granted port's ack SHALL be 1 exactly during DONE; the other ack stays 0.
REQ-022 Latency: req sampled at edge k -> ack high in cycle k+2+WAIT_CYCLES; next transfer's SETUP no earlier than k+3+WAIT_CYCLES.
REQ-023 Requester SHALL drop req in the cycle after ack; req still high in IDLE starts a new transfer, subject to round-robin.
REQ-024 A req arriving during a transfer SHALL wait, without loss, until IDLE.
REQ-025 Write with we=1 and read with we=0 SHALL never drive sram_dq_oe and sram_oe_n active in the same cycle.

Reset
REQ-026 reset_n=0 SHALL immediately (asynchronously) force: FSM IDLE; sram_ce_n, oe_n, we_n, ub_n, lb_n = 1; sram_dq_oe=0; sram_addr=0; sram_dq_o=0; cpu_do=dma_do=0; acks=0; last grant=DMA.
REQ-027 Reset mid-transfer SHALL abort with no ack; after release, a held req restarts from IDLE.

Verification
REQ-028 CPU read a=0x00003, SRAM word 0x5AA5, WAIT_CYCLES=2 -> sram_addr=0x00001, ub_n=0, cpu_do=0x5A, cpu_ack in cycle k+4.
REQ-029 DMA write a=0x7FFFE di=0x3C -> sram_addr=0x3FFFF, lb_n=0, dq_o=0x3C3C, we_n=0 for 2 cycles, dq_oe spans SETUP to DONE.
REQ-030 Both reqs high from reset, held continuously -> grant order CPU, DMA, CPU, DMA; each ack one cycle.
REQ-031 dma_req asserted during CPU ACCESS -> DMA SETUP starts exactly one cycle after CPU DONE (IDLE cycle between).
REQ-032 reset_n low during ACCESS of a write -> we_n=1, ce_n=1, dq_oe=0 within the same cycle; no ack; held req completes normally after release.
REQ-033 WAIT_CYCLES=1 and 15 -> ack in cycle k+3 and k+17 respectively.
